// File: rtl/apb_slave_mem_responder_if.sv
// APB4 completer-side bus bundle: request fields from the master, response back.
interface apb_slave_mem_responder_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDRESS_WIDTH-1:0]  paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic [2:0]                pprot;
    logic                      pready;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_slave_mem_responder.sv
// APB4 completer backed by a small word memory, with programmable wait states,
// deterministic address/protection errors and a saturating error counter.
module apb_slave_mem_responder #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       MEM_DEPTH     = 16,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
    parameter bit                       SECURE_ONLY   = 1'b0
) (
    input  logic                     pclk,
    input  logic                     preset_n,
    apb_slave_mem_responder_if.slave apb,
    input  logic [3:0]               wait_states,
    output logic [15:0]              err_count
);
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int ALIGN_BITS = $clog2(BYTES);
    localparam int IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] MEM_BYTES  = ADDRESS_WIDTH'(MEM_DEPTH * BYTES);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(BYTES - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic                  wr;
        logic [IDX_W-1:0]      idx;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BYTES-1:0]      strb;
        logic                  err;
    } req_t;

    state_t                                state_q, state_d;
    logic [3:0]                            cnt_q;
    req_t                                  req_q;
    logic [DATA_WIDTH-1:0]                 prdata_q;
    logic [MEM_DEPTH-1:0][DATA_WIDTH-1:0]  mem_q;

    logic                     setup, done, abort, addr_err;
    logic [ADDRESS_WIDTH-1:0] offset;
    logic [IDX_W-1:0]         idx_d;
    logic                     unused_pprot;

    assign setup  = (state_q == IDLE) && apb.psel && !apb.penable;
    assign done   = (state_q == ACCESS) && (cnt_q == 4'd0) && apb.psel && apb.penable;
    assign abort  = (state_q == ACCESS) && !apb.psel;
    assign offset = apb.paddr - BASE_ADDR;
    assign idx_d  = IDX_W'(offset >> ALIGN_BITS);

    // The decision is taken once at setup, so the response stays fixed for the whole access phase.
    assign addr_err = (apb.paddr < BASE_ADDR) || (offset >= MEM_BYTES) ||
                      ((apb.paddr & ALIGN_MASK) != '0) ||
                      (SECURE_ONLY && apb.pprot[1]);

    assign unused_pprot = ^{apb.pprot[2], apb.pprot[0]};

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (setup) state_d = ACCESS;
            ACCESS:  if (abort || done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        apb.pready = 1'b0;
        if (state_q == ACCESS && cnt_q == 4'd0) apb.pready = 1'b1;
    end

    assign apb.prdata  = prdata_q;
    assign apb.pslverr = req_q.err;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt_q     <= 4'd0;
            req_q     <= '0;
            prdata_q  <= '0;
            mem_q     <= '0;
            err_count <= 16'd0;
        end else begin
            if (setup) begin
                cnt_q <= wait_states;
                req_q <= '{wr: apb.pwrite, idx: idx_d, wdata: apb.pwdata,
                           strb: apb.pstrb, err: addr_err};
                if (!apb.pwrite) prdata_q <= addr_err ? '0 : mem_q[idx_d];
            end else if (state_q == ACCESS && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            // Commit on the completion edge so a back-to-back read sees the new data.
            if (done) begin
                if (req_q.wr && !req_q.err) begin
                    for (int b = 0; b < BYTES; b++)
                        if (req_q.strb[b]) mem_q[req_q.idx][b*8 +: 8] <= req_q.wdata[b*8 +: 8];
                end
                if (req_q.err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
        end
    end
endmodule
